// File: rtl/arashi_mt_ring_if.sv
// Bus bundle between the per-thread ctrl/data side and the shared arashi ring buffer.
// The master drives requests and write data; the slave (the ring) returns grants, read data and fill status.
interface arashi_mt_ring_if #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WIDTH  = 10,
   parameter int THREAD_NUM = 4
);
   logic [2*THREAD_NUM-1:0]          ctrl;
   logic [DATA_WIDTH*THREAD_NUM-1:0] data_in;
   logic [THREAD_NUM-1:0]            w_ready;
   logic [THREAD_NUM-1:0]            r_ready;
   logic [DATA_WIDTH*THREAD_NUM-1:0] data_out;
   logic [MEM_WIDTH:0]               level;
   logic                             full;
   logic                             empty;

   modport master (
      output ctrl, data_in,
      input  w_ready, r_ready, data_out, level, full, empty
   );

   modport slave (
      input  ctrl, data_in,
      output w_ready, r_ready, data_out, level, full, empty
   );
endinterface

// File: rtl/arashi_mt_ring.sv
// Shared multi-thread FIFO ring with round-robin write/read arbitration and fill-level reporting.
// Optional saturating drop counter on blocked writes is enabled by defining ARASHI_DROP_CNT_EN.
module arashi_mt_ring #(
   parameter int DATA_WIDTH       = 32,
   parameter int MEM_WIDTH        = 10,
   parameter int THREAD_NUM_WIDTH = 2,
   parameter int DROP_CNT_WIDTH   = 16
) (
   input logic             clk,
   input logic             rstn,
   arashi_mt_ring_if.slave bus
`ifdef ARASHI_DROP_CNT_EN
   ,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

   localparam int THREAD_NUM = 1 << THREAD_NUM_WIDTH;
   localparam int DEPTH      = 1 << MEM_WIDTH;
   localparam int RR_W       = (THREAD_NUM_WIDTH == 0) ? 1 : THREAD_NUM_WIDTH;
   localparam int SLOTS      = 1 << RR_W;
   localparam logic [MEM_WIDTH:0] DEPTH_L = (MEM_WIDTH + 1)'(DEPTH);

   if (THREAD_NUM_WIDTH < 0 || THREAD_NUM_WIDTH > 4) begin : g_bad_threads
      $error("arashi_mt_ring: THREAD_NUM_WIDTH must be within 0..4");
   end
   if (DROP_CNT_WIDTH < 1) begin : g_bad_drop
      $error("arashi_mt_ring: DROP_CNT_WIDTH must be at least 1");
   end

   logic [DATA_WIDTH-1:0]            mem [DEPTH];
   logic [MEM_WIDTH-1:0]             wr_ptr, rd_ptr;
   logic [MEM_WIDTH:0]               level;
   logic [RR_W-1:0]                  wr_rr, rd_rr, wr_rr_next, rd_rr_next;
   logic [THREAD_NUM-1:0]            pending;
   logic [DATA_WIDTH*THREAD_NUM-1:0] data_q;
   logic [SLOTS-1:0]                 w_req, r_req, w_grant, r_grant;
   logic [DATA_WIDTH-1:0]            w_data;
   logic                             full, empty, w_fire, r_fire;

   function automatic logic [SLOTS-1:0] rr_pick(input logic [SLOTS-1:0] req,
                                                input logic [RR_W-1:0]  start);
      logic [SLOTS-1:0] grant;
      logic [RR_W-1:0]  idx;
      grant = '0;
      for (int k = 0; k < SLOTS; k++) begin
         idx = start + RR_W'(k);
         if (req[idx] && grant == '0) grant[idx] = 1'b1;
      end
      return grant;
   endfunction

   function automatic logic [RR_W-1:0] rr_next(input logic [SLOTS-1:0] grant,
                                               input logic [RR_W-1:0]  cur);
      logic [RR_W-1:0] nxt;
      nxt = cur;
      for (int i = 0; i < SLOTS; i++) begin
         if (grant[i]) nxt = (THREAD_NUM == 1) ? '0 : RR_W'(i + 1);
      end
      return nxt;
   endfunction

   assign full  = (level == DEPTH_L);
   assign empty = (level == '0);

   // Request vectors are padded to a power-of-two slot count so the RR index wraps naturally;
   // a thread with a read still in flight is not eligible for another read grant.
   always_comb begin
      w_req = '0;
      r_req = '0;
      for (int i = 0; i < THREAD_NUM; i++) begin
         w_req[i] = bus.ctrl[2*i+1];
         r_req[i] = bus.ctrl[2*i] & ~pending[i];
      end
   end

   always_comb begin
      w_grant = '0;
      r_grant = '0;
      if (rstn && !full)  w_grant = rr_pick(w_req, wr_rr);
      if (rstn && !empty) r_grant = rr_pick(r_req, rd_rr);
      wr_rr_next = rr_next(w_grant, wr_rr);
      rd_rr_next = rr_next(r_grant, rd_rr);
      w_fire     = |w_grant;
      r_fire     = |r_grant;
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < THREAD_NUM; i++) begin
         if (w_grant[i]) w_data = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_fire) mem[wr_ptr] <= w_data;
   end

   // pending doubles as the r_ready pulse: set for exactly the cycle after the grant.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         wr_rr   <= '0;
         rd_rr   <= '0;
         pending <= '0;
         data_q  <= '0;
      end else begin
         if (w_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            wr_rr  <= wr_rr_next;
         end
         if (r_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_rr  <= rd_rr_next;
         end
         if (w_fire && !r_fire)      level <= level + 1'b1;
         else if (!w_fire && r_fire) level <= level - 1'b1;
         pending <= r_grant[THREAD_NUM-1:0];
         for (int i = 0; i < THREAD_NUM; i++) begin
            if (r_grant[i]) data_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[rd_ptr];
         end
      end
   end

`ifdef ARASHI_DROP_CNT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         drop_cnt <= '0;
      end else if (full && (|w_req) && !(&drop_cnt)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

   assign bus.w_ready  = w_grant[THREAD_NUM-1:0];
   assign bus.r_ready  = pending;
   assign bus.data_out = data_q;
   assign bus.level    = level;
   assign bus.full     = full;
   assign bus.empty    = empty;

endmodule

// File: tb/tb_arashi_mt_ring.sv
// Directed, table-driven bench for arashi_mt_ring with 4 threads and a depth-4 ring.
// Each vector is one clock: w_ready is sampled mid-cycle, registered outputs just after the edge.
module tb_arashi_mt_ring;

   typedef struct {
      logic         rstn;
      logic [7:0]   ctrl;
      logic [127:0] data;
      logic [3:0]   exp_w;
      logic [3:0]   exp_r;
      logic [2:0]   exp_lvl;
      logic         exp_full;
      logic         exp_empty;
      int           chk_slot;
      logic [31:0]  exp_data;
   } vec_t;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   arashi_mt_ring_if #(.DATA_WIDTH(32), .MEM_WIDTH(2), .THREAD_NUM(4)) bus ();

`ifdef ARASHI_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   arashi_mt_ring #(
      .DATA_WIDTH(32),
      .MEM_WIDTH(2),
      .THREAD_NUM_WIDTH(2),
      .DROP_CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus)
`ifdef ARASHI_DROP_CNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not reach its end within the time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic r, input logic [7:0] c, input logic [127:0] d,
                               input logic [3:0] w, input logic [3:0] rr, input logic [2:0] lvl,
                               input logic f, input logic e, input int slot, input logic [31:0] xd);
      vec_t v;
      v.rstn = r; v.ctrl = c; v.data = d; v.exp_w = w; v.exp_r = rr; v.exp_lvl = lvl;
      v.exp_full = f; v.exp_empty = e; v.chk_slot = slot; v.exp_data = xd;
      return v;
   endfunction

   function automatic logic [127:0] dat(input int slot, input logic [31:0] value);
      return 128'(value) << (32 * slot);
   endfunction

   task automatic checkValue(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [7:0] c, input logic [127:0] d);
      rstn        = r;
      bus.ctrl    = c;
      bus.data_in = d;
   endtask

   task automatic checkOutput(input string tag, input vec_t v);
      checkValue({tag, " r_ready"}, 128'(bus.r_ready), 128'(v.exp_r));
      checkValue({tag, " level"},   128'(bus.level),   128'(v.exp_lvl));
      checkValue({tag, " full"},    128'(bus.full),    128'(v.exp_full));
      checkValue({tag, " empty"},   128'(bus.empty),   128'(v.exp_empty));
      if (v.chk_slot >= 0)
         checkValue({tag, " data_out"}, 128'(bus.data_out[v.chk_slot*32 +: 32]), 128'(v.exp_data));
   endtask

   task automatic runVector(input string tag, input vec_t v);
      applyStimulus(v.rstn, v.ctrl, v.data);
      #4;
      checkValue({tag, " w_ready"}, 128'(bus.w_ready), 128'(v.exp_w));
      @(posedge clk);
      #1;
      checkOutput(tag, v);
   endtask

   localparam logic [127:0] D4 = {32'h13, 32'h12, 32'h11, 32'h10};

   initial begin
      vec_t vecs[$];
      vec_t v;
      checks = 0;
      errors = 0;
      applyStimulus(1'b0, 8'hFF, 128'h0);
      @(posedge clk);
      #1;

      // reset with every request asserted
      vecs.push_back(mk(0, 8'hFF, 128'h0, 4'h0, 4'h0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'hFF, 128'h0, 4'h0, 4'h0, 0, 0, 1, -1, 32'h0));
      vecs.push_back(mk(0, 8'hFF, 128'h0, 4'h0, 4'h0, 0, 0, 1, 3, 32'h0));
      // single thread write then read
      vecs.push_back(mk(1, 8'h02, dat(0, 32'hA5A5_0001), 4'h1, 4'h0, 1, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'h01, 128'h0, 4'h0, 4'h1, 0, 0, 1, 0, 32'hA5A5_0001));
      vecs.push_back(mk(1, 8'h00, 128'h0, 4'h0, 4'h0, 0, 0, 1, 0, 32'hA5A5_0001));
      // fresh RR pointers, then all four threads write continuously
      vecs.push_back(mk(0, 8'h00, 128'h0, 4'h0, 4'h0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(1, 8'hAA, D4, 4'h1, 4'h0, 1, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'hAA, D4, 4'h2, 4'h0, 2, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'hAA, D4, 4'h4, 4'h0, 3, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'hAA, D4, 4'h8, 4'h0, 4, 1, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'hAA, D4, 4'h0, 4'h0, 4, 1, 0, -1, 32'h0));
      // t2 drains: grant every other cycle because of its in-flight read
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h4, 3, 0, 0, 2, 32'h10));
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h0, 3, 0, 0, 2, 32'h10));
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h4, 2, 0, 0, 2, 32'h11));
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h0, 2, 0, 0, 2, 32'h11));
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h4, 1, 0, 0, 2, 32'h12));
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h0, 1, 0, 0, 2, 32'h12));
      vecs.push_back(mk(1, 8'h10, 128'h0, 4'h0, 4'h4, 0, 0, 1, 2, 32'h13));
      vecs.push_back(mk(1, 8'h00, 128'h0, 4'h0, 4'h0, 0, 0, 1, 2, 32'h13));
      // refill, then full with t1 write and t0 read in the same cycle
      vecs.push_back(mk(1, 8'h02, dat(0, 32'h20), 4'h1, 4'h0, 1, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'h02, dat(0, 32'h21), 4'h1, 4'h0, 2, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'h02, dat(0, 32'h22), 4'h1, 4'h0, 3, 0, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'h02, dat(0, 32'h23), 4'h1, 4'h0, 4, 1, 0, -1, 32'h0));
      vecs.push_back(mk(1, 8'h09, dat(1, 32'h30), 4'h0, 4'h1, 3, 0, 0, 0, 32'h20));
      vecs.push_back(mk(1, 8'h09, dat(1, 32'h30), 4'h2, 4'h0, 4, 1, 0, 0, 32'h20));
      // drain across two reader threads in global FIFO order
      vecs.push_back(mk(1, 8'h01, 128'h0, 4'h0, 4'h1, 3, 0, 0, 0, 32'h21));
      vecs.push_back(mk(1, 8'h04, 128'h0, 4'h0, 4'h2, 2, 0, 0, 1, 32'h22));
      vecs.push_back(mk(1, 8'h01, 128'h0, 4'h0, 4'h1, 1, 0, 0, 0, 32'h23));
      vecs.push_back(mk(1, 8'h04, 128'h0, 4'h0, 4'h2, 0, 0, 1, 1, 32'h30));

      foreach (vecs[i]) runVector($sformatf("vec%0d", i), vecs[i]);

      // pointer wrap: t3 writes every cycle while t0/t1 alternate reads, level stays at 1
      for (int k = 0; k < 10; k++) begin
         int reader;
         reader = k % 2;
         v = mk(1, 8'h80 | ((k > 0) ? 8'(1 << (2 * reader)) : 8'h00), dat(3, 32'h5000 + k),
                4'h8, (k > 0) ? 4'(1 << reader) : 4'h0, 1, 0, 0,
                (k > 0) ? reader : -1, 32'h5000 + k - 1);
         runVector($sformatf("wrap%0d", k), v);
      end
      runVector("wrap_end", mk(1, 8'h01, 128'h0, 4'h0, 4'h1, 0, 0, 1, 0, 32'h5009));

      // reset lands in the read-grant cycle: the stored word and its read are discarded
      runVector("rst_mid_wr", mk(1, 8'h02, dat(0, 32'h77), 4'h1, 4'h0, 1, 0, 0, -1, 32'h0));
      runVector("rst_mid_rd", mk(0, 8'h01, 128'h0, 4'h0, 4'h0, 0, 0, 1, 0, 32'h0));
      runVector("rst_after",  mk(1, 8'h01, 128'h0, 4'h0, 4'h0, 0, 0, 1, 0, 32'h0));
`ifdef ARASHI_DROP_CNT_EN
      checkValue("drop_cnt after reset", 128'(drop_cnt), 128'd0);
`endif

      // fill, then three blocked write cycles at full, then one idle cycle at full
      for (int n = 0; n < 4; n++)
         runVector($sformatf("drop_fill%0d", n),
                   mk(1, 8'h02, dat(0, 32'h90 + n), 4'h1, 4'h0, 3'(n + 1), (n == 3), 0, -1, 32'h0));
      for (int n = 0; n < 3; n++) begin
         runVector($sformatf("drop_blk%0d", n), mk(1, 8'hAA, D4, 4'h0, 4'h0, 4, 1, 0, -1, 32'h0));
`ifdef ARASHI_DROP_CNT_EN
         checkValue($sformatf("drop_cnt blk%0d", n), 128'(drop_cnt), 128'(n + 1));
`endif
      end
      runVector("drop_idle", mk(1, 8'h00, 128'h0, 4'h0, 4'h0, 4, 1, 0, -1, 32'h0));
`ifdef ARASHI_DROP_CNT_EN
      checkValue("drop_cnt idle", 128'(drop_cnt), 128'd3);
`endif
      runVector("drop_read", mk(1, 8'h40, 128'h0, 4'h0, 4'h8, 3, 0, 0, 3, 32'h90));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
